lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter RegBusWidth, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  1  EX-stage result valid this cycle.
REQ-005 SHALL have port memop_i  input  4  memory op: 0000 NONE, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; other codes are treated as NONE.
REQ-006 SHALL have port addr_i  input  32  EX ALU result: effective address, or pass-through result for NONE.
REQ-007 SHALL have port wdata_i  input  32  store data (rs2).
REQ-008 SHALL have port dm_req_o  output  1  data-memory request.
REQ-009 SHALL have port dm_we_o  output  4  byte write enables; 0000 = read.
REQ-010 SHALL have port dm_addr_o  output  32  word-aligned memory address.
REQ-011 SHALL have port dm_wdata_o  output  32  lane-replicated store data.
REQ-012 SHALL have port dm_ack_i  input  1  memory completion.
REQ-013 SHALL have port dm_rdata_i  input  32  read word, valid with dm_ack_i.
REQ-014 SHALL have port result_o  output  32  writeback data.
REQ-015 SHALL have port result_valid_o  output  1  one-cycle completion pulse.
REQ-016 SHALL have port stallreq_o  output  1  pipeline stall request (combinational).
REQ-017 SHALL have port misalign_o  output  1  misaligned-access pulse.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT only.
REQ-019 In IDLE with req_valid_i=1 and memop NONE, SHALL register result_o=addr_i and result_valid_o=1 for the next cycle (latency 1); state stays IDLE.
REQ-020 In IDLE with req_valid_i=1 and a load/store op, SHALL capture op/address/data and move to WAIT; stallreq_o=1 in that cycle.
REQ-021 In WAIT, SHALL hold dm_req_o=1 with stable dm_addr_o/dm_we_o/dm_wdata_o; stallreq_o=1 until the cycle dm_ack_i=1 is sampled.
REQ-022 On dm_ack_i=1 in WAIT, SHALL return to IDLE and, in the next cycle, pulse result_valid_o with result_o = extended load data (loads) or 0 (stores); stallreq_o=0 from that cycle.
REQ-023 Memory latency: op accepted at cycle T, ack at T+k (k>=1) -> result_valid_o at T+k+1.
REQ-024 dm_ack_i outside WAIT SHALL be ignored.
REQ-025 dm_addr_o SHALL equal {addr[31:2],2'b00}.
REQ-026 Stores: SB dm_we_o=1<<addr[1:0], byte replicated x4; SH dm_we_o=0011 (addr[1]=0) or 1100, half replicated x2; SW 1111, data unchanged. Loads: dm_we_o=0000.
REQ-027 Loads SHALL select the lane by addr[1:0] (byte) or addr[1] (half); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-028 req_valid_i=0 in IDLE SHALL produce no activity; inputs SHALL be ignored while in WAIT.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, with dm_req_o=0, dm_we_o=0, dm_addr_o=0, dm_wdata_o=0, result_o=0, result_valid_o=0, misalign_o=0, stallreq_o=0.
REQ-030 Reset during WAIT SHALL abandon the access; a late dm_ack_i SHALL be ignored per REQ-024.

Configuration
REQ-031 With LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no memory request, stay in IDLE, keep stallreq_o=0 and result_valid_o=0, and pulse misalign_o for one cycle in the next cycle.
REQ-032 Without LSU_MISALIGN_TRAP_EN: misalign_o SHALL be tied 0; halfword ops ignore addr[0] and word ops ignore addr[1:0].

Verification
REQ-033 NONE, addr_i=0x1234_5678 -> next cycle result_o=0x1234_5678, result_valid_o=1, no dm_req_o.
REQ-034 LB addr=0x103, dm_rdata_i=0x80FF_0000, ack after 3 cycles -> dm_addr_o=0x100, result_o=0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-035 SH addr=0x202, wdata_i=0xAAAA_BEEF -> dm_we_o=1100, dm_wdata_o=0xBEEF_BEEF, result_valid_o after ack, result_o=0.
REQ-036 LW with ack in the first WAIT cycle -> result_valid_o at T+2; stallreq_o high exactly T and T+1.
REQ-037 rst pulsed during WAIT, then dm_ack_i -> dm_req_o drops asynchronously, no result_valid_o.
REQ-038 LSU_MISALIGN_TRAP_EN defined, LW addr=0x101 -> misalign_o pulses once, dm_req_o stays 0; without the macro -> dm_addr_o=0x100, normal completion.

Source files
------------

// File: rtl/lsu_if.sv
// lsu_if: groups the LSU pipeline-side and data-memory-side signals.
// Ports: req_valid_i/memop_i/addr_i/wdata_i (request), dm_* (memory bus),
//        result_o/result_valid_o/stallreq_o/misalign_o (writeback/control).
interface lsu_if #(
  parameter int RegBusWidth = 32
);
  // pipeline request
  logic                   req_valid_i;
  logic [3:0]             memop_i;
  logic [31:0]            addr_i;
  logic [RegBusWidth-1:0] wdata_i;
  // data-memory bus
  logic                   dm_req_o;
  logic [3:0]             dm_we_o;
  logic [31:0]            dm_addr_o;
  logic [RegBusWidth-1:0] dm_wdata_o;
  logic                   dm_ack_i;
  logic [RegBusWidth-1:0] dm_rdata_i;
  // writeback / pipeline control
  logic [RegBusWidth-1:0] result_o;
  logic                   result_valid_o;
  logic                   stallreq_o;
  logic                   misalign_o;

  // slave: the LSU itself
  modport slave (
    input  req_valid_i, memop_i, addr_i, wdata_i, dm_ack_i, dm_rdata_i,
    output dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
           result_o, result_valid_o, stallreq_o, misalign_o
  );

  // master: pipeline + memory environment driving the LSU
  modport master (
    output req_valid_i, memop_i, addr_i, wdata_i, dm_ack_i, dm_rdata_i,
    input  dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
           result_o, result_valid_o, stallreq_o, misalign_o
  );
endinterface

// File: rtl/lsu.sv
// lsu: load/store unit between EX stage and a single-port data memory.
// Latency: non-memory ops 1 cycle; memory ops ack cycle + 1; one access in flight.
// Backpressure: stallreq_o (combinational) high from accept through the ack cycle.
// Ports: clk, rst (async, active-high), bus (lsu_if.slave).
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word ops trap
// via misalign_o instead of touching memory; otherwise low address bits ignored).
module lsu #(
  parameter int RegBusWidth = 32
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t state, state_nxt;

  // request decode
  logic       is_load, is_store, is_signed, is_mem, misaligned;
  logic [1:0] size;
  logic       accept, passthru, trap;

  // store lane steering for the incoming request
  logic [3:0]  we_calc;
  logic [31:0] wdata_calc;

  // access captured at accept time, held for the whole WAIT
  logic [3:0]  dm_we_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wdata_q;
  logic [1:0]  size_q, off_q;
  logic        load_q, signed_q;

  logic [RegBusWidth-1:0] result_q;
  logic                   result_valid_q;
  logic                   misalign_q;

  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;
  logic [RegBusWidth-1:0] ld_val;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_B;
    case (bus.memop_i)
      4'b0001: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_B; end
      4'b0010: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_H; end
      4'b0011: begin is_load  = 1'b1;                   size = SZ_W; end
      4'b0100: begin is_load  = 1'b1;                   size = SZ_B; end
      4'b0101: begin is_load  = 1'b1;                   size = SZ_H; end
      4'b1001: begin is_store = 1'b1;                   size = SZ_B; end
      4'b1010: begin is_store = 1'b1;                   size = SZ_H; end
      4'b1011: begin is_store = 1'b1;                   size = SZ_W; end
      default: ;  // unknown codes behave as NONE (pass-through)
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = is_mem &&
                      (((size == SZ_H) && bus.addr_i[0]) ||
                       ((size == SZ_W) && (bus.addr_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Halfword lane is picked by addr[1] only, so addr[0] is naturally ignored
  // when trapping is disabled; word ops ignore both low bits.
  always_comb begin
    we_calc    = 4'b0000;
    wdata_calc = bus.wdata_i;
    case (size)
      SZ_B: begin
        we_calc    = 4'b0001 << bus.addr_i[1:0];
        wdata_calc = {4{bus.wdata_i[7:0]}};
      end
      SZ_H: begin
        we_calc    = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{bus.wdata_i[15:0]}};
      end
      default: begin
        we_calc    = 4'b1111;
        wdata_calc = bus.wdata_i;
      end
    endcase
    if (!is_store) we_calc = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    passthru       = 1'b0;
    trap           = 1'b0;
    bus.stallreq_o = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (!is_mem) begin
            passthru = 1'b1;
          end else if (misaligned) begin
            trap = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        // ack is the last stalled cycle; the result appears the cycle after
        if (bus.dm_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // rst gating keeps the stall low while reset is asserted, even with a
    // memory request presented on the inputs
    bus.stallreq_o = !rst && (accept || (state == WAIT));
  end

  // byte/half lane extraction from the returned word
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.dm_rdata_i[7:0];
      2'd1:    ld_byte = bus.dm_rdata_i[15:8];
      2'd2:    ld_byte = bus.dm_rdata_i[23:16];
      default: ld_byte = bus.dm_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? bus.dm_rdata_i[31:16] : bus.dm_rdata_i[15:0];
    case (size_q)
      SZ_B:    ld_val = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      SZ_H:    ld_val = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_val = bus.dm_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_we_q        <= 4'b0000;
      dm_addr_q      <= 32'h0;
      dm_wdata_q     <= 32'h0;
      size_q         <= SZ_B;
      off_q          <= 2'b00;
      load_q         <= 1'b0;
      signed_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      misalign_q     <= 1'b0;
      if (passthru) begin
        result_q       <= bus.addr_i;
        result_valid_q <= 1'b1;
      end
      if (trap) misalign_q <= 1'b1;
      if (accept) begin
        dm_addr_q  <= {bus.addr_i[31:2], 2'b00};
        dm_we_q    <= we_calc;
        dm_wdata_q <= wdata_calc;
        size_q     <= size;
        off_q      <= bus.addr_i[1:0];
        load_q     <= is_load;
        signed_q   <= is_signed;
      end
      if ((state == WAIT) && bus.dm_ack_i) begin
        result_valid_q <= 1'b1;
        result_q       <= load_q ? ld_val : '0;
      end
    end
  end

  // Memory bus is only driven while an access is outstanding; since state is
  // async-reset, a reset mid-access drops the request immediately.
  assign bus.dm_req_o       = (state == WAIT);
  assign bus.dm_we_o        = (state == WAIT) ? dm_we_q    : 4'b0000;
  assign bus.dm_addr_o      = (state == WAIT) ? dm_addr_q  : 32'h0;
  assign bus.dm_wdata_o     = (state == WAIT) ? dm_wdata_q : 32'h0;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = result_valid_q;
  assign bus.misalign_o     = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed + randomized self-checking bench for lsu.
// Expected values come from a byte-arithmetic reference model of the LSU rules.
module tb_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  lsu_if #(.RegBusWidth(32)) bus ();

  lsu #(.RegBusWidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference model: derives bus and result values from byte offsets and sizes.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic [3:0] we, output logic [31:0] dwd,
                                output logic [31:0] res, output bit mem, output bit mis);
    int unsigned off, sz, lane;
    bit ld, st, sg;
    logic [31:0] v;
    off = a % 4; ld = 0; st = 0; sg = 0; sz = 0;
    case (op)
      4'd1:  begin ld = 1; sz = 1; sg = 1; end
      4'd2:  begin ld = 1; sz = 2; sg = 1; end
      4'd3:  begin ld = 1; sz = 4; end
      4'd4:  begin ld = 1; sz = 1; end
      4'd5:  begin ld = 1; sz = 2; end
      4'd9:  begin st = 1; sz = 1; end
      4'd10: begin st = 1; sz = 2; end
      4'd11: begin st = 1; sz = 4; end
      default: ;
    endcase
    mem = ld | st;
    mis = 0;
    lane = 0;
    if (mem) begin
      lane = off - (off % sz);
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (off % sz) != 0;
`endif
    end
    we = 4'h0; dwd = wd; res = 32'h0;
    if (st) begin
      we = 4'(((1 << sz) - 1) << lane);
      if (sz == 1)      dwd = 32'((wd & 32'hFF) * 32'h01010101);
      else if (sz == 2) dwd = 32'((wd & 32'hFFFF) * 32'h00010001);
    end
    if (ld) begin
      v = rd >> (8 * lane);
      if (sz == 1) begin
        v = v & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
      end
      res = v;
    end
    if (!mem) res = a;
  endfunction

  // Issues one request at a known idle point and checks it to completion.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int k, input string nm,
                        output logic [31:0] o_res, output logic [3:0] o_we,
                        output logic [31:0] o_addr, output logic [31:0] o_wd);
    logic [3:0] e_we; logic [31:0] e_wd, e_res; bit e_mem, e_mis;
    model(op, a, wd, rd, e_we, e_wd, e_res, e_mem, e_mis);
    o_res = 32'h0; o_we = 4'h0; o_addr = 32'h0; o_wd = 32'h0;
    bus.req_valid_i = 1'b1; bus.memop_i = op; bus.addr_i = a; bus.wdata_i = wd;
    bus.dm_ack_i = 1'b0;
    #1;
    if (!e_mem) begin
      chk({nm, "_pt_stall"}, 32'(bus.stallreq_o), 32'h0);
      cyc();
      bus.req_valid_i = 1'b0;
      chk({nm, "_pt_valid"}, 32'(bus.result_valid_o), 32'h1);
      chk({nm, "_pt_result"}, bus.result_o, e_res);
      chk({nm, "_pt_dmreq"}, 32'(bus.dm_req_o), 32'h0);
      o_res = bus.result_o;
      cyc();
      chk({nm, "_pt_valid_drop"}, 32'(bus.result_valid_o), 32'h0);
    end else if (e_mis) begin
      chk({nm, "_mis_stall"}, 32'(bus.stallreq_o), 32'h0);
      cyc();
      bus.req_valid_i = 1'b0;
      chk({nm, "_mis_pulse"}, 32'(bus.misalign_o), 32'h1);
      chk({nm, "_mis_dmreq"}, 32'(bus.dm_req_o), 32'h0);
      chk({nm, "_mis_valid"}, 32'(bus.result_valid_o), 32'h0);
      o_res = 32'(bus.misalign_o);
      cyc();
      chk({nm, "_mis_drop"}, 32'(bus.misalign_o), 32'h0);
      chk({nm, "_mis_idle"}, 32'(bus.dm_req_o), 32'h0);
    end else begin
      chk({nm, "_acc_stall"}, 32'(bus.stallreq_o), 32'h1);
      cyc();
      // junk on the request inputs while waiting must not disturb the access
      bus.req_valid_i = 1'($urandom_range(0, 1));
      bus.memop_i = 4'($urandom_range(0, 15));
      bus.addr_i = $urandom; bus.wdata_i = $urandom;
      for (int i = 1; i <= k; i++) begin
        bus.dm_ack_i = (i == k);
        bus.dm_rdata_i = (i == k) ? rd : $urandom;
        #1;
        chk({nm, "_wait_dmreq"}, 32'(bus.dm_req_o), 32'h1);
        chk({nm, "_wait_addr"}, bus.dm_addr_o, a & 32'hFFFF_FFFC);
        chk({nm, "_wait_we"}, 32'(bus.dm_we_o), 32'(e_we));
        if (e_we != 4'h0) chk({nm, "_wait_wdata"}, bus.dm_wdata_o, e_wd);
        chk({nm, "_wait_stall"}, 32'(bus.stallreq_o), 32'h1);
        chk({nm, "_wait_novalid"}, 32'(bus.result_valid_o), 32'h0);
        o_we = bus.dm_we_o; o_addr = bus.dm_addr_o; o_wd = bus.dm_wdata_o;
        cyc();
      end
      bus.dm_ack_i = 1'b0; bus.req_valid_i = 1'b0; bus.dm_rdata_i = $urandom;
      #1;
      chk({nm, "_done_valid"}, 32'(bus.result_valid_o), 32'h1);
      chk({nm, "_done_result"}, bus.result_o, e_res);
      chk({nm, "_done_stall"}, 32'(bus.stallreq_o), 32'h0);
      chk({nm, "_done_dmreq"}, 32'(bus.dm_req_o), 32'h0);
      o_res = bus.result_o;
      cyc();
      chk({nm, "_done_drop"}, 32'(bus.result_valid_o), 32'h0);
    end
  endtask

  initial begin
    logic [31:0] r, ad, wdo;
    logic [3:0]  we;
    logic [3:0]  rop;
    logic [3:0]  ops [10];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7};

    // reset with a memory request presented: everything must stay quiet
    bus.req_valid_i = 1'b1; bus.memop_i = 4'b0011; bus.addr_i = 32'h40;
    bus.wdata_i = 32'h0; bus.dm_ack_i = 1'b0; bus.dm_rdata_i = 32'h0;
    #3;
    chk("rst_dm_req", 32'(bus.dm_req_o), 32'h0);
    chk("rst_dm_we", 32'(bus.dm_we_o), 32'h0);
    chk("rst_dm_addr", bus.dm_addr_o, 32'h0);
    chk("rst_dm_wdata", bus.dm_wdata_o, 32'h0);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_result_valid", 32'(bus.result_valid_o), 32'h0);
    chk("rst_misalign", 32'(bus.misalign_o), 32'h0);
    chk("rst_stallreq", 32'(bus.stallreq_o), 32'h0);
    bus.req_valid_i = 1'b0;
    #9 rst = 1'b0;
    cyc();

    // idle with no request: no activity
    #1;
    chk("idle_stall", 32'(bus.stallreq_o), 32'h0);
    cyc();
    chk("idle_valid", 32'(bus.result_valid_o), 32'h0);
    chk("idle_dmreq", 32'(bus.dm_req_o), 32'h0);

    // pass-through and unknown opcode
    run_op(4'b0000, 32'h1234_5678, 32'h0, 32'h0, 1, "none", r, we, ad, wdo);
    chk("none_const", r, 32'h1234_5678);
    run_op(4'b0111, 32'hDEAD_0001, 32'h0, 32'h0, 1, "badop", r, we, ad, wdo);
    chk("badop_const", r, 32'hDEAD_0001);

    // byte loads with 3-cycle memory
    run_op(4'b0001, 32'h103, $urandom, 32'h80FF_0000, 3, "lb", r, we, ad, wdo);
    chk("lb_const_res", r, 32'hFFFF_FF80);
    chk("lb_const_addr", ad, 32'h100);
    run_op(4'b0100, 32'h103, $urandom, 32'h80FF_0000, 3, "lbu", r, we, ad, wdo);
    chk("lbu_const_res", r, 32'h0000_0080);

    // upper-half store
    run_op(4'b1010, 32'h202, 32'hAAAA_BEEF, $urandom, 2, "sh", r, we, ad, wdo);
    chk("sh_const_we", 32'(we), 32'hC);
    chk("sh_const_wdata", wdo, 32'hBEEF_BEEF);
    chk("sh_const_res", r, 32'h0);

    // word load acked in the first wait cycle
    run_op(4'b0011, 32'h300, $urandom, 32'hCAFE_F00D, 1, "lw1", r, we, ad, wdo);
    chk("lw1_const_res", r, 32'hCAFE_F00D);

    // ack while idle is ignored
    bus.dm_ack_i = 1'b1; bus.dm_rdata_i = 32'h5555_5555;
    cyc();
    bus.dm_ack_i = 1'b0;
    chk("stray_ack_valid", 32'(bus.result_valid_o), 32'h0);
    chk("stray_ack_dmreq", 32'(bus.dm_req_o), 32'h0);
    chk("stray_ack_stall", 32'(bus.stallreq_o), 32'h0);

    // reset in the middle of an access, then a late ack
    bus.req_valid_i = 1'b1; bus.memop_i = 4'b0011; bus.addr_i = 32'h400;
    cyc();
    bus.req_valid_i = 1'b0;
    chk("rstw_dmreq_before", 32'(bus.dm_req_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstw_dmreq_async", 32'(bus.dm_req_o), 32'h0);
    chk("rstw_stall_async", 32'(bus.stallreq_o), 32'h0);
    #2 rst = 1'b0;
    bus.dm_ack_i = 1'b1; bus.dm_rdata_i = 32'h1111_2222;
    cyc();
    bus.dm_ack_i = 1'b0;
    chk("rstw_late_ack_valid", 32'(bus.result_valid_o), 32'h0);
    cyc();
    chk("rstw_late_ack_valid2", 32'(bus.result_valid_o), 32'h0);
    chk("rstw_idle_dmreq", 32'(bus.dm_req_o), 32'h0);

    // misaligned word load
    run_op(4'b0011, 32'h101, $urandom, 32'h7654_3210, 2, "lw_mis", r, we, ad, wdo);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_trap_seen", r, 32'h1);
`else
    chk("lw_mis_const_addr", ad, 32'h100);
    chk("lw_mis_const_res", r, 32'h7654_3210);
`endif

    // randomized operations against the model
    for (int n = 0; n < 60; n++) begin
      rop = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) rop = 4'($urandom_range(0, 15));
      run_op(rop, $urandom, $urandom, $urandom, int'($urandom_range(1, 4)), "rnd",
             r, we, ad, wdo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
